// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 receive front end that filters ps2c/ps2d, deserialises
// 11-bit device-to-host frames and decodes make/break/extended scan codes into
// held key levels and press strobes for keys A, S, D, B and Enter.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   rst         in   asynchronous reset, active-low
//   ps2d        in   PS/2 data, asynchronous
//   ps2c        in   PS/2 clock, asynchronous
//   key_a       out  A held (make 1C)
//   key_s       out  S held (make 1B)
//   key_d       out  D held (make 23)
//   key_b       out  B held (make 32)
//   key_enter   out  Enter held (make 5A or E0 5A)
//   key_press   out  one-cycle press strobes {enter,b,d,s,a}
//   scan_code   out  last good frame payload
//   scan_valid  out  one-cycle pulse, scan_code updated
//   frame_err   out  one-cycle pulse on a bad or aborted frame
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       key_a,
    output logic       key_s,
    output logic       key_d,
    output logic       key_b,
    output logic       key_enter,
    output logic [4:0] key_press,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic            c_s1, c_s2, d_s1, d_s2;
    logic            c_f, c_f_d;
    logic [FW-1:0]   f_cnt;
    logic [WW-1:0]   wd;
    logic [10:0]     sh;
    logic [3:0]      bit_cnt;
    logic [4:0]      keys;
    logic            brk, ext;
    logic            fall, ok, good, bad, timeout;
    logic [7:0]      code;
    logic [4:0]      hit;

    // Edge taken from the registered filtered clock, adding one cycle so that
    // scan_valid lands two cycles after the filtered 11th falling edge.
    assign fall = c_f_d & ~c_f;
    // sh holds {stop, parity, data[7:0], start} once eleven bits are in.
    assign ok   = ~sh[0] & sh[10] & ^sh[9:1];
    assign code = sh[8:1];
    assign hit  = ext ? {code == 8'h5A, 4'b0000}
                      : {code == 8'h5A, code == 8'h32, code == 8'h23,
                         code == 8'h1B, code == 8'h1C};
    assign {key_enter, key_b, key_d, key_s, key_a} = keys;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        good    = 1'b0;
        bad     = 1'b0;
        timeout = 1'b0;
        unique case (state)
            IDLE:  state_n = fall ? SHIFT : IDLE;
            SHIFT: begin
                if (fall && bit_cnt == 4'd10) begin
                    state_n = DONE;
                end else if (!fall && wd == WW'(TIMEOUT_CYC - 1)) begin
                    state_n = IDLE;
                    timeout = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                good    = ok;
                bad     = ~ok;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {c_s1, c_s2, d_s1, d_s2, c_f, c_f_d} <= '1;
            f_cnt      <= '0;
            wd         <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            keys       <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            key_press  <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            {c_s1, c_s2} <= {ps2c, c_s1};
            {d_s1, d_s2} <= {ps2d, d_s1};
            c_f_d        <= c_f;
            if (c_s2 == c_f) begin
                f_cnt <= '0;
            end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
                c_f   <= c_s2;
                f_cnt <= '0;
            end else begin
                f_cnt <= f_cnt + 1'b1;
            end
            if (fall) begin
                sh      <= {d_s2, sh[10:1]};
                bit_cnt <= (state == IDLE) ? 4'd1 : bit_cnt + 4'd1;
            end
            wd         <= (state == SHIFT && !fall) ? wd + 1'b1 : '0;
            scan_valid <= good;
            frame_err  <= bad | timeout;
            // Strobe only on a real 0->1 transition so typematic repeats stay quiet.
            key_press  <= (good && !brk) ? hit & ~keys : '0;
            if (good) begin
                scan_code <= code;
                if (code == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk  <= 1'b0;
                    ext  <= 1'b0;
                    keys <= brk ? keys & ~hit : keys | hit;
                end
            end else if (bad || timeout) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench driving PS/2 frames into ps2_key_decoder.
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       key_a, key_s, key_d, key_b, key_enter;
    logic [4:0] key_press;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;
    logic [4:0] keys_now;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [4:0] keys;
        logic [4:0] press;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    ps2_key_decoder dut (
        .clk(clk), .rst(rst), .ps2d(ps2d), .ps2c(ps2c),
        .key_a(key_a), .key_s(key_s), .key_d(key_d), .key_b(key_b),
        .key_enter(key_enter), .key_press(key_press), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_err(frame_err)
    );

    assign keys_now = {key_enter, key_b, key_d, key_s, key_a};

    always #5 clk = ~clk;

    // Monitor: pops the next expected event whenever the DUT reports a frame.
    always @(negedge clk) begin
        if (rst && (scan_valid || frame_err)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output valid=%0b err=%0b code=%h keys=%b press=%b",
                         scan_valid, frame_err, scan_code, keys_now, key_press);
            end else begin
                e = q.pop_front();
                if ({frame_err, scan_valid, scan_code, keys_now, key_press} !==
                    {e.err, ~e.err, e.code, e.keys, e.press}) begin
                    errors++;
                    $display("FAIL %s got err=%0b valid=%0b code=%h keys=%b press=%b want err=%0b valid=%0b code=%h keys=%b press=%b",
                             e.name, frame_err, scan_valid, scan_code, keys_now, key_press,
                             e.err, ~e.err, e.code, e.keys, e.press);
                end
            end
        end
        if (rst && !scan_valid && key_press !== 5'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_strobe got press=%b want 00000", key_press);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit err, input logic [7:0] code, input logic [4:0] keys,
                             input logic [4:0] press, input string name);
        exp_t x;
        x.err = err; x.code = code; x.keys = keys; x.press = press; x.name = name;
        q.push_back(x);
    endtask

    task automatic send_bits(input logic [7:0] data, input bit flip, input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~^data;
        p = p ^ flip;
        f = {1'b1, p, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (10) @(posedge clk);
            ps2c = 1'b0;
            repeat (20) @(posedge clk);
            ps2c = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2d = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain"}, q.size(), 0);
        q.delete();
        repeat (40) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] code, input logic [4:0] keys, input logic [4:0] press,
                         input string name);
        expect_ev(1'b0, code, keys, press, name);
        send_bits(code, 1'b0, 11);
        wait_drain(name, 200);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {scan_valid, frame_err, scan_code, keys_now, key_press}, 32'h0);
        @(posedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);

        // make A, typematic repeats, then break
        frame(8'h1C, 5'b00001, 5'b00001, "make_a");
        frame(8'h1C, 5'b00001, 5'b00000, "repeat_a1");
        frame(8'h1C, 5'b00001, 5'b00000, "repeat_a2");
        frame(8'h1C, 5'b00001, 5'b00000, "repeat_a3");
        frame(8'hF0, 5'b00001, 5'b00000, "break_prefix");
        frame(8'h1C, 5'b00000, 5'b00000, "break_a");

        // parity error: scan_code keeps 1C, S not pressed
        expect_ev(1'b1, 8'h1C, 5'b00000, 5'b00000, "bad_parity");
        send_bits(8'h1B, 1'b1, 11);
        wait_drain("bad_parity", 200);

        // partial frame left to time out
        expect_ev(1'b1, 8'h1C, 5'b00000, 5'b00000, "timeout");
        send_bits(8'h55, 1'b0, 5);
        wait_drain("timeout", 25000);
        frame(8'h23, 5'b00100, 5'b00100, "make_d");

        // extended Enter plus B, then extended break of Enter
        frame(8'hE0, 5'b00100, 5'b00000, "ext_prefix");
        frame(8'h5A, 5'b10100, 5'b10000, "make_enter");
        frame(8'h32, 5'b11100, 5'b01000, "make_b");
        frame(8'hE0, 5'b11100, 5'b00000, "ext_prefix2");
        frame(8'hF0, 5'b11100, 5'b00000, "ext_break_prefix");
        frame(8'h5A, 5'b01100, 5'b00000, "break_enter");
        frame(8'hE0, 5'b01100, 5'b00000, "ext_prefix3");
        frame(8'h1C, 5'b01100, 5'b00000, "ext_unmapped");

        // short ps2c glitch must not count as a bit
        ps2c = 1'b0;
        repeat (4) @(posedge clk);
        ps2c = 1'b1;
        repeat (50) @(posedge clk);
        frame(8'h1B, 5'b01110, 5'b00010, "after_glitch");

        // reset in the middle of a frame
        send_bits(8'h1C, 1'b0, 5);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs", {scan_valid, frame_err, scan_code, keys_now, key_press}, 32'h0);
        @(posedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        frame(8'h1C, 5'b00001, 5'b00001, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
